// File: rtl/fp_accumulator_if.sv
// Term stream into the FP32 accumulator and result/status stream out of it.
// Latency: none; this is wiring only.
// Backpressure: none; terms are fire-and-forget pulses and the result is a one-cycle pulse.
//
// Signals:
//   input_a      FP32 term, valid only while input_a_stb is high
//   input_a_stb  one-cycle term strobe, no acknowledge
//   input_last   marks the term that closes the current sum
//   output_z     last completed sum, held until the next one
//   output_z_stb one-cycle pulse when output_z updates
//   busy         adder FSM working or terms still queued
//   drop         sticky flag, a term was lost to a full FIFO
interface fp_accumulator_if;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_last;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        busy;
    logic        drop;

    // Producer side (multiplier / stimulus).
    modport master (
        output input_a,
        output input_a_stb,
        output input_last,
        input  output_z,
        input  output_z_stb,
        input  busy,
        input  drop
    );

    // Accumulator side.
    modport slave (
        input  input_a,
        input  input_a_stb,
        input  input_last,
        output output_z,
        output output_z_stb,
        output busy,
        output drop
    );
endinterface

// File: rtl/fp_accumulator.sv
// Streaming FP32 accumulator: sums tagged terms, emits the total on the term marked last, restarts at +0.
// Latency: variable per term (3 cycles for a zero accumulator, longer when aligning/normalising); result pulse one cycle after emit.
// Backpressure: none upstream; a DEPTH-entry FIFO absorbs bursts and terms arriving at a full FIFO are discarded (sticky drop).
//
// Ports: clk, rst (synchronous, active-high), bus (fp_accumulator_if.slave: input_a/_stb/input_last in,
//        output_z/_stb, busy, drop out). Parameter DEPTH: FIFO entries, power of two, >= 2.
module fp_accumulator #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    fp_accumulator_if.slave    bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [3:0] {
        IDLE,
        UNPACK,
        SPECIAL_CASES,
        ALIGN,
        ADD_0,
        ADD_1,
        NORMALISE_1,
        NORMALISE_2,
        ROUND,
        PACK,
        EMIT
    } state_t;

    // Unbiased exponent; a zero field is the denormal exponent -126.
    function automatic logic signed [9:0] unpack_exp(input logic [7:0] field);
        logic signed [9:0] e;
        if (field == 8'd0) begin
            e = -10'sd126;
        end else begin
            e = $signed({2'b00, field}) - 10'sd127;
        end
        return e;
    endfunction

    // {hidden, fraction, guard, round, sticky}
    function automatic logic [26:0] unpack_man(input logic [31:0] x);
        return {x[30:23] != 8'd0, x[22:0], 3'b000};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q, state_d;

    logic [32:0]       fifo_mem_q [DEPTH];
    logic [32:0]       fifo_mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic [31:0]       acc_q, acc_d;
    logic [31:0]       b_q, b_d;
    logic              last_q, last_d;

    logic [26:0]       a_m_q, a_m_d;
    logic [26:0]       b_m_q, b_m_d;
    logic signed [9:0] a_e_q, a_e_d;
    logic signed [9:0] b_e_q, b_e_d;
    logic              a_s_q, a_s_d;
    logic              b_s_q, b_s_d;

    logic [27:0]       sum_q, sum_d;
    logic [23:0]       z_m_q, z_m_d;
    logic signed [9:0] z_e_q, z_e_d;
    logic              z_s_q, z_s_d;
    logic              guard_q, guard_d;
    logic              rnd_q, rnd_d;
    logic              sticky_q, sticky_d;

    logic [31:0]       out_z_q, out_z_d;
    logic              out_stb_q, out_stb_d;
    logic              drop_q, drop_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              pop;
    logic              push;
    logic [32:0]       head;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic signed [9:0] e_diff;
    logic signed [9:0] biased_e;

    assign pop    = (state_q == IDLE) && (count_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push   = bus.input_a_stb && ((count_q < CW'(DEPTH)) || pop);
    assign head   = fifo_mem_q[rd_ptr_q];

    assign a_nan  = (acc_q[30:23] == 8'hFF) && (acc_q[22:0] != 23'd0);
    assign b_nan  = (b_q[30:23]   == 8'hFF) && (b_q[22:0]   != 23'd0);
    assign a_inf  = (acc_q[30:23] == 8'hFF) && (acc_q[22:0] == 23'd0);
    assign b_inf  = (b_q[30:23]   == 8'hFF) && (b_q[22:0]   == 23'd0);
    assign a_zero = (acc_q[30:0] == 31'd0);
    assign b_zero = (b_q[30:0]   == 31'd0);

    assign e_diff   = a_e_q - b_e_q;
    assign biased_e = z_e_q + 10'sd127;

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_d     = drop_q;

        if (push) begin
            fifo_mem_d[wr_ptr_q] = {bus.input_last, bus.input_a};
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (bus.input_a_stb && !push) begin
            drop_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Adder FSM: next state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        b_d       = b_q;
        last_d    = last_q;
        a_m_d     = a_m_q;
        b_m_d     = b_m_q;
        a_e_d     = a_e_q;
        b_e_d     = b_e_q;
        a_s_d     = a_s_q;
        b_s_d     = b_s_q;
        sum_d     = sum_q;
        z_m_d     = z_m_q;
        z_e_d     = z_e_q;
        z_s_d     = z_s_q;
        guard_d   = guard_q;
        rnd_d     = rnd_q;
        sticky_d  = sticky_q;
        out_z_d   = out_z_q;
        out_stb_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    b_d     = head[31:0];
                    last_d  = head[32];
                    state_d = UNPACK;
                end
            end

            UNPACK: begin
                a_m_d   = unpack_man(acc_q);
                b_m_d   = unpack_man(b_q);
                a_e_d   = unpack_exp(acc_q[30:23]);
                b_e_d   = unpack_exp(b_q[30:23]);
                a_s_d   = acc_q[31];
                b_s_d   = b_q[31];
                state_d = SPECIAL_CASES;
            end

            SPECIAL_CASES: begin
                state_d = last_q ? EMIT : IDLE;
                if (a_nan || b_nan) begin
                    acc_d = 32'hFFC0_0000;
                end else if (a_inf && b_inf) begin
                    acc_d = (acc_q[31] != b_q[31]) ? 32'hFFC0_0000 : acc_q;
                end else if (a_inf) begin
                    acc_d = acc_q;
                end else if (b_inf) begin
                    acc_d = b_q;
                end else if (a_zero && b_zero) begin
                    acc_d = {acc_q[31] & b_q[31], 31'd0};
                end else if (a_zero) begin
                    acc_d = b_q;
                end else if (b_zero) begin
                    acc_d = acc_q;
                end else begin
                    state_d = ALIGN;
                end
            end

            // One bit per cycle; the shifted-out bits fold into the sticky LSB.
            ALIGN: begin
                if (a_e_q > b_e_q) begin
                    if (e_diff > 10'sd26) begin
                        b_m_d = {26'd0, |b_m_q};
                        b_e_d = a_e_q;
                    end else begin
                        b_m_d = {1'b0, b_m_q[26:2], b_m_q[1] | b_m_q[0]};
                        b_e_d = b_e_q + 10'sd1;
                    end
                end else if (a_e_q < b_e_q) begin
                    if (e_diff < -10'sd26) begin
                        a_m_d = {26'd0, |a_m_q};
                        a_e_d = b_e_q;
                    end else begin
                        a_m_d = {1'b0, a_m_q[26:2], a_m_q[1] | a_m_q[0]};
                        a_e_d = a_e_q + 10'sd1;
                    end
                end else begin
                    state_d = ADD_0;
                end
            end

            ADD_0: begin
                z_e_d = a_e_q;
                if (a_s_q == b_s_q) begin
                    sum_d = {1'b0, a_m_q} + {1'b0, b_m_q};
                    z_s_d = a_s_q;
                end else if (a_m_q >= b_m_q) begin
                    sum_d = {1'b0, a_m_q - b_m_q};
                    z_s_d = a_s_q;
                end else begin
                    sum_d = {1'b0, b_m_q - a_m_q};
                    z_s_d = b_s_q;
                end
                state_d = ADD_1;
            end

            ADD_1: begin
                if (sum_q == 28'd0) begin
                    // Exact cancellation always yields +0.
                    acc_d   = 32'h0000_0000;
                    state_d = last_q ? EMIT : IDLE;
                end else begin
                    if (sum_q[27]) begin
                        z_m_d    = sum_q[27:4];
                        guard_d  = sum_q[3];
                        rnd_d    = sum_q[2];
                        sticky_d = sum_q[1] | sum_q[0];
                        z_e_d    = z_e_q + 10'sd1;
                    end else begin
                        z_m_d    = sum_q[26:3];
                        guard_d  = sum_q[2];
                        rnd_d    = sum_q[1];
                        sticky_d = sum_q[0];
                    end
                    state_d = NORMALISE_1;
                end
            end

            // Left-normalise, but never below the denormal exponent.
            NORMALISE_1: begin
                if (!z_m_q[23] && (z_e_q > -10'sd126)) begin
                    z_m_d   = {z_m_q[22:0], guard_q};
                    guard_d = rnd_q;
                    rnd_d   = 1'b0;
                    z_e_d   = z_e_q - 10'sd1;
                end else begin
                    state_d = NORMALISE_2;
                end
            end

            NORMALISE_2: begin
                if (z_e_q < -10'sd126) begin
                    z_m_d    = {1'b0, z_m_q[23:1]};
                    guard_d  = z_m_q[0];
                    rnd_d    = guard_q;
                    sticky_d = sticky_q | rnd_q;
                    z_e_d    = z_e_q + 10'sd1;
                end else begin
                    state_d = ROUND;
                end
            end

            ROUND: begin
                if (guard_q && (rnd_q || sticky_q || z_m_q[0])) begin
                    z_m_d = z_m_q + 24'd1;
                    // All-ones mantissa wraps to zero: value becomes 1.0 x 2^(e+1).
                    if (z_m_q == 24'hFF_FFFF) begin
                        z_e_d = z_e_q + 10'sd1;
                    end
                end
                state_d = PACK;
            end

            PACK: begin
                acc_d = {z_s_q, biased_e[7:0], z_m_q[22:0]};
                if ((z_e_q == -10'sd126) && !z_m_q[23]) begin
                    acc_d[30:23] = 8'd0;
                end
                if (z_e_q > 10'sd127) begin
                    acc_d = {z_s_q, 8'hFF, 23'd0};
                end
                state_d = last_q ? EMIT : IDLE;
            end

            EMIT: begin
                out_z_d   = acc_q;
                out_stb_d = 1'b1;
                acc_d     = 32'h0000_0000;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // FIFO storage needs no reset: count_q alone defines validity.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            acc_q     <= 32'd0;
            b_q       <= 32'd0;
            last_q    <= 1'b0;
            a_m_q     <= 27'd0;
            b_m_q     <= 27'd0;
            a_e_q     <= 10'sd0;
            b_e_q     <= 10'sd0;
            a_s_q     <= 1'b0;
            b_s_q     <= 1'b0;
            sum_q     <= 28'd0;
            z_m_q     <= 24'd0;
            z_e_q     <= 10'sd0;
            z_s_q     <= 1'b0;
            guard_q   <= 1'b0;
            rnd_q     <= 1'b0;
            sticky_q  <= 1'b0;
            out_z_q   <= 32'd0;
            out_stb_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            last_q    <= last_d;
            a_m_q     <= a_m_d;
            b_m_q     <= b_m_d;
            a_e_q     <= a_e_d;
            b_e_q     <= b_e_d;
            a_s_q     <= a_s_d;
            b_s_q     <= b_s_d;
            sum_q     <= sum_d;
            z_m_q     <= z_m_d;
            z_e_q     <= z_e_d;
            z_s_q     <= z_s_d;
            guard_q   <= guard_d;
            rnd_q     <= rnd_d;
            sticky_q  <= sticky_d;
            out_z_q   <= out_z_d;
            out_stb_q <= out_stb_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.output_z     = out_z_q;
    assign bus.output_z_stb = out_stb_q;
    assign bus.drop         = drop_q;
    assign bus.busy         = (state_q != IDLE) || (count_q != '0);

endmodule
